// File: rtl/riscv_pkg.sv
// Shared core types: ALU control encodings, the reservation-station issue bundle, and tag sizing.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_WIDTH = 6;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_MUL    = 4'd8,
    ALU_MULH   = 4'd9,
    ALU_MULHSU = 4'd10,
    ALU_MULHU  = 4'd11
  } alu_ctrl_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      operand_a;
    logic [XLEN-1:0]      operand_b;
    alu_ctrl_e            alu_ctrl;
    logic [TAG_WIDTH-1:0] dest_tag;
  } rs_fu_s;

endpackage

// File: rtl/cdb_if.sv
// Common data bus: one request/payload lane per producer, one grant per producer.
interface cdb_if
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_PROD   = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_W      = TAG_WIDTH
);

  logic [NUM_PROD-1:0]                 req;
  logic [NUM_PROD-1:0]                 grant;
  logic [NUM_PROD-1:0]                 exception_in;
  logic [NUM_PROD-1:0][TAG_W-1:0]      tag_in;
  logic [NUM_PROD-1:0][DATA_WIDTH-1:0] data_in;

  modport producer (
    output req,
    output tag_in,
    output data_in,
    output exception_in,
    input  grant
  );

  modport arbiter (
    input  req,
    input  tag_in,
    input  data_in,
    input  exception_in,
    output grant
  );

endinterface

// File: rtl/seq_mul_core.sv
// Unsigned shift-add multiplier retiring BPC multiplier bits per cycle over WIDTH/BPC cycles.
module seq_mul_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = WIDTH + BPC;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [AW-1:0]     sum;
  logic [AW+WIDTH-1:0] shifted;

  // One iteration: add mag_a * low digit of Q, then shift {acc, Q} right by one digit.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    q_d     = q_q;
    sum     = acc_q + AW'(a_q) * AW'(q_q[BPC-1:0]);
    shifted = {sum, q_q} >> BPC;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_LAST;
      acc_d  = '0;
      a_d    = mag_a;
      q_d    = mag_b;
    end else if (busy_q) begin
      acc_d = shifted[AW+WIDTH-1:WIDTH];
      q_d   = shifted[WIDTH-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      q_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      q_q    <= q_d;
    end
  end

  // The top digit of acc is always clear once the final shift has happened.
  assign done    = busy_q && (cnt_q == '0);
  assign product = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/alu_mul_param.sv
// RV32M multiply functional unit: sign prep, iterative core, sign fix-up and a one-entry CDB result buffer.
module alu_mul_param
  import riscv_pkg::*;
#(
  parameter int unsigned ID    = 0,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rs_fu_s  alu_in,
  output logic    free,
  cdb_if.producer cdb
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]            state_q, state_d;
  alu_ctrl_e             ctrl_q, ctrl_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  neg_q, neg_d;
  logic                  valid_out_q, valid_out_d;
  logic [WIDTH-1:0]      data_out_q, data_out_d;
  logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;
  logic                  free_q;

  logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;
  logic             sign_a, sign_b, start;
  logic             core_done;
  logic [PW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] result;
  logic             grant;

  assign grant = cdb.grant[ID];

  // Sign prep on the live issue bundle; the core latches the magnitudes on start.
  always_comb begin
    op_a   = alu_in.operand_a[WIDTH-1:0];
    op_b   = alu_in.operand_b[WIDTH-1:0];
    sign_a = ((alu_in.alu_ctrl == ALU_MULH) || (alu_in.alu_ctrl == ALU_MULHSU)) && op_a[WIDTH-1];
    sign_b = (alu_in.alu_ctrl == ALU_MULH) && op_b[WIDTH-1];
    mag_a  = sign_a ? (~op_a + WIDTH'(1)) : op_a;
    mag_b  = sign_b ? (~op_b + WIDTH'(1)) : op_b;
    start  = (state_q == S_IDLE) && alu_in.valid;
  end

  seq_mul_core #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .done    (core_done),
    .product (prod)
  );

  always_comb begin
    prod_s = neg_q ? (~prod + PW'(1)) : prod;
    case (ctrl_q)
      ALU_MUL:                         result = prod_s[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod_s[PW-1:WIDTH];
      default:                         result = '0;
    endcase
  end

  // Next state; a FIX write into the buffer takes priority over a same-cycle grant clear.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    tag_d       = tag_q;
    neg_d       = neg_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    tag_out_d   = tag_out_q;
    if (grant) begin
      valid_out_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (alu_in.valid) begin
          ctrl_d  = alu_in.alu_ctrl;
          tag_d   = alu_in.dest_tag;
          neg_d   = sign_a ^ sign_b;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (core_done) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!valid_out_q || grant) begin
          valid_out_d = 1'b1;
          data_out_d  = result;
          tag_out_d   = tag_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctrl_q      <= ALU_ADD;
      tag_q       <= '0;
      neg_q       <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
      free_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      tag_q       <= tag_d;
      neg_q       <= neg_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
      free_q      <= (state_d == S_IDLE);
    end
  end

  assign free                 = free_q;
  assign cdb.req[ID]          = valid_out_q;
  assign cdb.tag_in[ID]       = tag_out_q;
  assign cdb.data_in[ID]      = data_out_q;
  assign cdb.exception_in[ID] = 1'b0;

endmodule

// File: tb/tb_alu_mul_param.sv
// Directed bench for alu_mul_param at BPC=1, 2 and 4: latency, all modes, back-pressure and reset abort.
module tb_alu_mul_param;
  import riscv_pkg::*;

  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  rs_fu_s               alu_in_s [NI];
  logic [NI-1:0]        grant_s, req_w, free_w, exc_w;
  logic [31:0]          data_w   [NI];
  logic [TAG_WIDTH-1:0] tag_w    [NI];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned BPC_G = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    cdb_if #(.NUM_PROD(1), .DATA_WIDTH(32)) u_cdb ();
    alu_mul_param #(.ID(0), .WIDTH(32), .BPC(BPC_G)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .alu_in (alu_in_s[g]),
      .free   (free_w[g]),
      .cdb    (u_cdb)
    );
    assign u_cdb.grant[0] = grant_s[g];
    assign req_w[g]       = u_cdb.req[0];
    assign exc_w[g]       = u_cdb.exception_in[0];
    assign data_w[g]      = u_cdb.data_in[0];
    assign tag_w[g]       = u_cdb.tag_in[0];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input alu_ctrl_e c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (c == ALU_MULH || c == ALU_MULHSU) ea = {{32{a[31]}}, a};
    if (c == ALU_MULH) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (c)
      ALU_MUL:                         return p[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: return p[63:32];
      default:                         return 32'h0;
    endcase
  endfunction

  task automatic wait_free(input int i);
    int n = 0;
    while (!free_w[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("free_wait", 32'(free_w[i]), 32'd1);
  endtask

  task automatic issue(input int i, input alu_ctrl_e c, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_WIDTH-1:0] t);
    alu_in_s[i] = '{valid: 1'b1, operand_a: a, operand_b: b, alu_ctrl: c, dest_tag: t};
    @(negedge clk);
    alu_in_s[i] = '0;
  endtask

  // Issue, measure cycles to req, check payload, then grant and check req drops.
  task automatic run_op(input int i, input alu_ctrl_e c, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_WIDTH-1:0] t, input logic [31:0] exp, input int n_iter,
                        input string name);
    int lat;
    int free_hi;
    wait_free(i);
    issue(i, c, a, b, t);
    lat = 1;
    free_hi = 0;
    while (!req_w[i] && lat < 200) begin
      if (free_w[i]) free_hi++;
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"},  32'(lat), 32'(n_iter + 2));
    check({name, "_data"}, data_w[i], exp);
    check({name, "_tag"},  32'(tag_w[i]), 32'(t));
    check({name, "_busy"}, 32'(free_hi), 32'd0);
    check({name, "_free"}, 32'(free_w[i]), 32'd1);
    grant_s[i] = 1'b1;
    @(negedge clk);
    grant_s[i] = 1'b0;
    check({name, "_req_drop"}, 32'(req_w[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_ctrl_e   modes [4];
    logic [31:0] ra, rb;
    int          n_req;
    modes = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    rst = 1'b1;
    grant_s = '0;
    for (int i = 0; i < NI; i++) alu_in_s[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      check("rst_req",  32'(req_w[i]),  32'd0);
      check("rst_free", 32'(free_w[i]), 32'd1);
      check("rst_data", data_w[i],      32'd0);
      check("rst_tag",  32'(tag_w[i]),  32'd0);
      check("rst_exc",  32'(exc_w[i]),  32'd0);
    end

    // BPC=1: latency and mode/sign corner cases
    run_op(0, ALU_MUL,    32'd7,        32'd6,        6'd5,  32'd42,        32, "mul_7x6");
    run_op(0, ALU_MULH,   32'h80000000, 32'h80000000, 6'd6,  32'h40000000, 32, "mulh_min");
    run_op(0, ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd7,  32'hFFFFFFFE, 32, "mulhu_max");
    run_op(0, ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 6'd8,  32'h00000001, 32, "mul_max");
    run_op(0, ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd9,  32'hFFFFFFFF, 32, "mulhsu_m1");
    run_op(0, ALU_MULH,   32'hFFFFFFFD, 32'd5,        6'd10, 32'hFFFFFFFF, 32, "mulh_m3x5");
    run_op(0, ALU_MUL,    32'hFFFFFFFD, 32'd5,        6'd11, 32'hFFFFFFF1, 32, "mul_m3x5");
    run_op(0, ALU_ADD,    32'd7,        32'd6,        6'd12, 32'd0,        32, "unknown");

    // BPC=2 and BPC=4: directed per mode, then random against the model
    for (int i = 1; i < NI; i++) begin
      int n;
      n = (i == 1) ? 16 : 8;
      run_op(i, ALU_MUL,    32'h12345678, 32'h00000010, 6'd20, 32'h23456780, n, "p_mul");
      run_op(i, ALU_MULH,   32'hFFFFFFFE, 32'h00000003, 6'd21, 32'hFFFFFFFF, n, "p_mulh");
      run_op(i, ALU_MULHSU, 32'h7FFFFFFF, 32'hFFFFFFFF, 6'd22, 32'h7FFFFFFE, n, "p_mulhsu");
      run_op(i, ALU_MULHU,  32'h80000000, 32'h00000004, 6'd23, 32'h00000002, n, "p_mulhu");
      run_op(i, ALU_MULH,   32'h80000000, 32'h80000000, 6'd24, 32'h40000000, n, "p_mulh_min");
      for (int k = 0; k < 8; k++) begin
        ra = $urandom;
        rb = $urandom;
        run_op(i, modes[k % 4], ra, rb, 6'(30 + k), ref_mul(modes[k % 4], ra, rb), n, "rand");
      end
    end

    // Back-pressure on BPC=4: second result stalls in FIX until the first is granted
    wait_free(2);
    issue(2, ALU_MUL, 32'd3, 32'd4, 6'd1);
    n_req = 0;
    while (!req_w[2] && n_req < 50) begin
      @(negedge clk);
      n_req++;
    end
    check("bp_first_req", 32'(req_w[2]), 32'd1);
    check("bp_free", 32'(free_w[2]), 32'd1);
    issue(2, ALU_MUL, 32'd5, 32'd5, 6'd2);
    repeat (12) @(negedge clk);
    check("bp_hold_req",  32'(req_w[2]),  32'd1);
    check("bp_hold_data", data_w[2],      32'd12);
    check("bp_hold_tag",  32'(tag_w[2]),  32'd1);
    check("bp_stall",     32'(free_w[2]), 32'd0);
    grant_s[2] = 1'b1;
    @(negedge clk);
    grant_s[2] = 1'b0;
    check("bp_second_req",  32'(req_w[2]),  32'd1);
    check("bp_second_data", data_w[2],      32'd25);
    check("bp_second_tag",  32'(tag_w[2]),  32'd2);
    check("bp_second_free", 32'(free_w[2]), 32'd1);
    grant_s[2] = 1'b1;
    @(negedge clk);
    grant_s[2] = 1'b0;
    check("bp_drop", 32'(req_w[2]), 32'd0);

    // Reset mid-CALC discards the operation
    wait_free(0);
    issue(0, ALU_MUL, 32'd7, 32'd6, 6'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req",  32'(req_w[0]),  32'd0);
    check("abort_free", 32'(free_w[0]), 32'd1);
    n_req = 0;
    repeat (40) begin
      if (req_w[0]) n_req++;
      @(negedge clk);
    end
    check("abort_no_req", 32'(n_req), 32'd0);
    run_op(0, ALU_MUL, 32'd3, 32'd3, 6'd4, 32'd9, 32, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
